// File: rtl/std_seq_mem_d1_if.sv
`default_nettype none
// ============================================================================
// Module   : std_seq_mem_d1_if
// Brief    : Request/response bundle for std_seq_mem_d1. The addr_err signal
//            exists only when STD_SEQ_MEM_BOUNDS_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface std_seq_mem_d1_if #(
   parameter int WIDTH    = 32,
   parameter int IDX_SIZE = 4
);
   logic [IDX_SIZE-1:0] addr0;
   logic                content_en;
   logic                write_en;
   logic [WIDTH-1:0]    write_data;
   logic [WIDTH-1:0]    read_data;
   logic                done;
`ifdef STD_SEQ_MEM_BOUNDS_CHECK_EN
   logic                addr_err;

   modport master (
      output addr0, content_en, write_en, write_data,
      input  read_data, done, addr_err
   );
   modport slave (
      input  addr0, content_en, write_en, write_data,
      output read_data, done, addr_err
   );
`else
   modport master (
      output addr0, content_en, write_en, write_data,
      input  read_data, done
   );
   modport slave (
      input  addr0, content_en, write_en, write_data,
      output read_data, done
   );
`endif
endinterface
`default_nettype wire

// File: rtl/std_seq_mem_d1.sv
`default_nettype none
// ============================================================================
// Module   : std_seq_mem_d1
// Brief    : Single-port word memory, one request per cycle, fixed LATENCY
//            completion pipeline. Optional macro STD_SEQ_MEM_BOUNDS_CHECK_EN
//            adds the addr_err out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module std_seq_mem_d1 #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4,
   parameter int LATENCY  = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   std_seq_mem_d1_if.slave bus
);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("std_seq_mem_d1: LATENCY=%0d outside legal range 1..4", LATENCY);
   end
   if ((2 ** IDX_SIZE) < SIZE) begin : g_bad_size
      $error("std_seq_mem_d1: 2**IDX_SIZE=%0d cannot address SIZE=%0d", 2 ** IDX_SIZE, SIZE);
   end

   // One extra bit so SIZE == 2**IDX_SIZE is representable
   localparam logic [IDX_SIZE:0] c_size = (IDX_SIZE + 1)'(SIZE);

   logic [WIDTH-1:0]   r_mem [SIZE];
   logic               w_oor;
   logic               w_req_rd;
   logic [WIDTH-1:0]   w_req_dat;
   logic               w_fin_rd;
   logic [WIDTH-1:0]   w_fin_dat;
   logic [LATENCY-1:0] r_vld;
   logic [WIDTH-1:0]   r_read_data;

   assign w_oor     = ({1'b0, bus.addr0} >= c_size);
   assign w_req_rd  = bus.content_en & ~bus.write_en;
   assign w_req_dat = w_oor ? '0 : r_mem[bus.addr0];

   always_ff @(posedge clk) begin
      if (reset_n && bus.content_en && bus.write_en && !w_oor) begin
         r_mem[bus.addr0] <= bus.write_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= bus.content_en;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // Read payload travels LATENCY-1 stages; the last stage is read_data itself
   if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0]            r_rd;
      logic [LATENCY-2:0][WIDTH-1:0] r_dat;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_rd  <= '0;
            r_dat <= '0;
         end else begin
            r_rd[0]  <= w_req_rd;
            r_dat[0] <= w_req_dat;
            for (int i = 1; i < LATENCY - 1; i++) begin
               r_rd[i]  <= r_rd[i-1];
               r_dat[i] <= r_dat[i-1];
            end
         end
      end

      assign w_fin_rd  = r_rd[LATENCY-2];
      assign w_fin_dat = r_dat[LATENCY-2];
   end else begin : g_nopipe
      assign w_fin_rd  = w_req_rd;
      assign w_fin_dat = w_req_dat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_read_data <= '0;
      end else if (w_fin_rd) begin
         r_read_data <= w_fin_dat;
      end
   end

   assign bus.done      = r_vld[LATENCY-1];
   assign bus.read_data = r_read_data;

`ifdef STD_SEQ_MEM_BOUNDS_CHECK_EN
   logic [LATENCY-1:0] r_oor;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oor <= '0;
      end else begin
         r_oor[0] <= bus.content_en & w_oor;
         for (int i = 1; i < LATENCY; i++) begin
            r_oor[i] <= r_oor[i-1];
         end
      end
   end

   assign bus.addr_err = r_oor[LATENCY-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_std_seq_mem_d1.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_seq_mem_d1
// Brief    : Drives LATENCY=1 and LATENCY=3 instances (SIZE=12) in lockstep
//            against a cycle-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_seq_mem_d1;

   localparam int WIDTH    = 32;
   localparam int SIZE     = 12;
   localparam int IDX_SIZE = 4;

   typedef struct packed {
      logic             vld;
      logic             rd;
      logic             oor;
      logic [WIDTH-1:0] dat;
   } ent_t;

   logic clk;
   logic reset_n;

   std_seq_mem_d1_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus1 ();
   std_seq_mem_d1_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus3 ();

   std_seq_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE), .LATENCY(1)) u_dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1.slave)
   );

   std_seq_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE), .LATENCY(3)) u_dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH-1:0] m_mem [16];
   ent_t             hist [0:4095];
   int               cyc  = 0;
   int               base = 0;
   logic [WIDTH-1:0] exp_rd1 = '0;
   logic [WIDTH-1:0] exp_rd3 = '0;

   task automatic check_value(input string tag, input logic [WIDTH-1:0] got,
                              input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Request accepted on edge k completes in the cycle after edge k+LAT-1
   function automatic ent_t exp_at(input int lat);
      int idx;
      idx = cyc - (lat - 1);
      if (idx > base) return hist[idx];
      return '0;
   endfunction

   task automatic drive(input logic ce, input logic we, input logic [IDX_SIZE-1:0] a,
                        input logic [WIDTH-1:0] d);
      bus1.content_en = ce; bus1.write_en = we; bus1.addr0 = a; bus1.write_data = d;
      bus3.content_en = ce; bus3.write_en = we; bus3.addr0 = a; bus3.write_data = d;
   endtask

   task automatic step(input logic ce, input logic we, input logic [IDX_SIZE-1:0] a,
                       input logic [WIDTH-1:0] d);
      ent_t e;
      ent_t e1;
      ent_t e3;
      @(negedge clk);
      drive(ce, we, a, d);
      @(posedge clk);
      cyc++;
      e.vld = ce;
      e.rd  = ce && !we;
      e.oor = ce && (int'(a) >= SIZE);
      e.dat = (e.rd && !e.oor) ? m_mem[a] : '0;
      if (ce && we && int'(a) < SIZE) m_mem[a] = d;
      hist[cyc] = e;
      #1;
      e1 = exp_at(1);
      e3 = exp_at(3);
      if (e1.rd) exp_rd1 = e1.dat;
      if (e3.rd) exp_rd3 = e3.dat;
      check_value("done_l1", {31'b0, bus1.done}, {31'b0, e1.vld});
      check_value("rdata_l1", bus1.read_data, exp_rd1);
      check_value("done_l3", {31'b0, bus3.done}, {31'b0, e3.vld});
      check_value("rdata_l3", bus3.read_data, exp_rd3);
`ifdef STD_SEQ_MEM_BOUNDS_CHECK_EN
      check_value("aerr_l1", {31'b0, bus1.addr_err}, {31'b0, e1.oor});
      check_value("aerr_l3", {31'b0, bus3.addr_err}, {31'b0, e3.oor});
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      reset_n = 1'b0;
      #1;
      exp_rd1 = '0;
      exp_rd3 = '0;
      check_value("rst_done_l1", {31'b0, bus1.done}, '0);
      check_value("rst_rdata_l1", bus1.read_data, '0);
      check_value("rst_done_l3", {31'b0, bus3.done}, '0);
      check_value("rst_rdata_l3", bus3.read_data, '0);
`ifdef STD_SEQ_MEM_BOUNDS_CHECK_EN
      check_value("rst_aerr_l1", {31'b0, bus1.addr_err}, '0);
      check_value("rst_aerr_l3", {31'b0, bus3.addr_err}, '0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = cyc;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      do_reset();

      // Preload every in-range word with k*0x11
      for (int k = 0; k < SIZE; k++) step(1'b1, 1'b1, 4'(k), WIDTH'(k * 32'h11));

      // Write then read-after-write on the next cycle
      step(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 4'd3, '0);
      // write_en without content_en is ignored
      step(1'b0, 1'b1, 4'd5, 32'h1);
      step(1'b1, 1'b0, 4'd5, '0);
      // read_data holds through a following write completion
      step(1'b1, 1'b1, 4'd1, 32'hA);
      step(1'b1, 1'b0, 4'd1, '0);
      step(1'b1, 1'b1, 4'd1, 32'hB);
      repeat (4) step(1'b0, 1'b0, '0, '0);
      // Out-of-range write suppressed, read returns zero, aliasing word untouched
      step(1'b1, 1'b1, 4'd12, 32'h5);
      step(1'b1, 1'b0, 4'd12, '0);
      step(1'b1, 1'b0, 4'd2, '0);
      step(1'b1, 1'b0, 4'd15, '0);
      // Back-to-back reads
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 4'(k), '0);
      repeat (4) step(1'b0, 1'b0, '0, '0);

      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), WIDTH'($urandom));
      end
      repeat (4) step(1'b0, 1'b0, '0, '0);

      // Reset with reads in flight: they must never complete
      step(1'b1, 1'b0, 4'd0, '0);
      step(1'b1, 1'b0, 4'd1, '0);
      do_reset();
      repeat (5) step(1'b0, 1'b0, '0, '0);
      for (int k = 0; k < SIZE; k++) step(1'b1, 1'b0, 4'(k), '0);
      repeat (4) step(1'b0, 1'b0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/std_seq_mem_d1.md
STD_SEQ_MEM_D1 -- requirements
Module: std_seq_mem_d1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 16, number of words.
REQ-003 SHALL have parameter IDX_SIZE, default 4, address width in bits.
REQ-004 SHALL have parameter LATENCY, default 1, cycles from request accept to done; legal range 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port addr0, input, IDX_SIZE, word address.
REQ-008 SHALL have port content_en, input, 1, request valid; one request is accepted per cycle while high.
REQ-009 SHALL have port write_en, input, 1, request type qualifier: 1 = write, 0 = read; ignored when content_en=0.
REQ-010 SHALL have port write_data, input, WIDTH, write payload.
REQ-011 SHALL have port read_data, output, WIDTH, read result.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse per accepted request.
REQ-013 SHALL have port addr_err, output, 1, out-of-range flag; present only when STD_SEQ_MEM_BOUNDS_CHECK_EN is defined.

Function
REQ-014 SHALL accept a request on every rising edge where content_en=1; there is no busy or back-pressure state.
REQ-015 SHALL commit a write to mem[addr0] on the accepting edge.
REQ-016 SHALL sample mem[addr0] for a read on the accepting edge, after any write committed on an earlier edge.
REQ-017 SHALL pulse done high for exactly one cycle, LATENCY cycles after each accept; back-to-back accepts give back-to-back done pulses.
REQ-018 SHALL update read_data only in the cycle done is asserted for a read; it holds its value through writes, idle cycles and write completions.
REQ-019 SHALL let a read accepted the cycle after a write to the same address return the new data.
REQ-020 SHALL treat addr0 >= SIZE as out of range: a write is suppressed, a read completes with read_data = 0, and done still pulses.
REQ-021 SHALL not truncate or wrap the address; out-of-range detection applies to the full addr0 value.
REQ-022 SHALL keep done low in every cycle with no completing request.
REQ-023 SHALL behave identically for every LATENCY value except for the done/read_data delay.
REQ-024 SHALL fail elaboration with an error message under VERILATOR when LATENCY is outside 1..4 or 2**IDX_SIZE < SIZE.

Reset
REQ-025 SHALL, while reset_n=0, force done=0, read_data=0 and addr_err=0, and clear all in-flight pipeline entries, independent of clk.
REQ-026 SHALL not initialise memory contents on reset; writes committed before reset assertion persist.
REQ-027 SHALL drop requests in flight at reset assertion, so no done pulse is produced for them after release.
REQ-028 SHALL accept requests from the first rising edge after reset_n goes high.

Configuration
REQ-029 SHALL compile in out-of-range reporting when macro STD_SEQ_MEM_BOUNDS_CHECK_EN is defined: addr_err is asserted in the same cycle as done for an out-of-range request, and is low otherwise.
REQ-030 SHALL omit port addr_err when STD_SEQ_MEM_BOUNDS_CHECK_EN is undefined; REQ-020 suppression and zero-read behaviour apply in both builds.

Verification
REQ-031 SHALL cover this case: LATENCY=1; write 0xDEADBEEF @3, then read @3 next cycle -> done pulses on cycles 1 and 2, read_data=0xDEADBEEF from cycle 2.
REQ-032 SHALL cover this case: LATENCY=3; read @0..@7 on 8 consecutive cycles after preload k*0x11 -> 8 consecutive done pulses starting 3 cycles after the first accept, read_data=0x00,0x11,..,0x77.
REQ-033 SHALL cover this case: SIZE=10, macro defined; write 0x5 @12, then read @12 -> both done pulses carry addr_err=1, read data=0, mem[2] unchanged.
REQ-034 SHALL cover this case: LATENCY=4; issue 2 reads, then pull reset_n low 2 cycles after the first accept -> done=0 and read_data=0 immediately, no done pulse after release, earlier-written data still readable.
REQ-035 SHALL cover this case: write_en=1 with content_en=0 at @5 holding 0x1, then read @5 -> old value returned, no done in the idle cycle.
REQ-036 SHALL cover this case: LATENCY=2; read @1 (=0xA), then write @1=0xB -> read_data=0xA at the first done and stays 0xA through the write's done.
